// File: rtl/xm_mem_ctrl.sv
// rtl/xm_mem_ctrl.sv - X/M memory-stage controller: store buffer, req/ack memory port, pipeline stall
`timescale 1ns/1ps
module xm_mem_ctrl #(
  parameter int         DATA_W = 32,
  parameter int         ADDR_W = 12,
  parameter int         DEPTH  = 4,
  parameter logic [4:0] OPC_SW = 5'b00111,
  parameter logic [4:0] OPC_LW = 5'b01000
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [31:0]                instruction,
  input  logic                       valid,
  input  logic [ADDR_W-1:0]          addr,
  input  logic [DATA_W-1:0]          wdata,
  output logic                       stall,
  output logic                       mem_req,
  output logic                       mem_we,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [DATA_W-1:0]          mem_wdata,
  input  logic                       mem_ack,
  input  logic [DATA_W-1:0]          mem_rdata,
  output logic [DATA_W-1:0]          load_data,
  output logic                       load_done,
  output logic [$clog2(DEPTH+1)-1:0] sb_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  typedef enum logic [1:0] {IDLE, WR, RD, RDONE} state_t;

  state_t            state;
  state_t            state_d;
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [ADDR_W-1:0] sb_addr [DEPTH];
  logic [DATA_W-1:0] sb_data [DEPTH];
  logic              is_sw;
  logic              is_lw;
  logic              full;
  logic              push;
  logic              pop;
  logic              unused_bits;

  assign unused_bits = ^instruction[26:0];

  assign is_sw = valid & (instruction[31:27] == OPC_SW);
  assign is_lw = valid & (instruction[31:27] == OPC_LW);
  assign full  = (sb_count == CNT_W'(DEPTH));
  // A full buffer refuses the push even when the head pops this cycle.
  assign push  = is_sw & ~full;
  assign pop   = (state == WR) & mem_ack;

  always_ff @(posedge clock) begin
    if (push) begin
      sb_addr[tail] <= addr;
      sb_data[tail] <= wdata;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head     <= '0;
      tail     <= '0;
      sb_count <= '0;
    end else begin
      if (push) tail <= tail + PTR_W'(1);
      if (pop)  head <= head + PTR_W'(1);
      case ({push, pop})
        2'b10:   sb_count <= sb_count + CNT_W'(1);
        2'b01:   sb_count <= sb_count - CNT_W'(1);
        default: sb_count <= sb_count;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  // Buffered stores drain before any load so memory sees program order.
  always_comb begin
    state_d = state;
    case (state)
      IDLE: begin
        if (sb_count != '0) state_d = WR;
        else if (is_lw)     state_d = RD;
      end
      WR:      if (mem_ack) state_d = IDLE;
      RD:      if (mem_ack) state_d = RDONE;
      RDONE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_req   = (state == WR) | (state == RD);
    mem_we    = (state == WR);
    load_done = (state == RDONE);
    stall     = ~reset & ((is_sw & full) | (is_lw & (state != RDONE)));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem_addr  <= '0;
      mem_wdata <= '0;
      load_data <= '0;
    end else begin
      if (state == IDLE) begin
        if (sb_count != '0) begin
          mem_addr  <= sb_addr[head];
          mem_wdata <= sb_data[head];
        end else if (is_lw) begin
          mem_addr  <= addr;
        end
      end
      if ((state == RD) && mem_ack) load_data <= mem_rdata;
    end
  end

endmodule
